// File: rtl/m68k_bus_responder_if.sv
// ----------------------------------------------------------------------------
// Module   : m68k_bus_responder_if
// Purpose  : Bundles the 68000-side bus and the simple slave-side bus.
//            The responder uses the slave modport. The CPU/slave model
//            (for example a testbench) uses the master modport.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface m68k_bus_responder_if #(
  parameter int ADDR_W = 32
);
  // CPU side
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_write;
  logic [15:0]       cpu_read;
  logic              as_n;
  logic              uds_n;
  logic              lds_n;
  logic              rw;
  logic              dtack_n;
  logic              berr_n;
  // Slave side
  logic [ADDR_W-1:0] slv_addr;
  logic [15:0]       slv_write;
  logic [15:0]       slv_read;
  logic              slv_ds;
  logic              slv_rw;
  logic [1:0]        slv_be;
  logic              slv_ack;

  modport slave (
    input  cpu_addr, cpu_write, as_n, uds_n, lds_n, rw, slv_read, slv_ack,
    output cpu_read, dtack_n, berr_n, slv_addr, slv_write, slv_ds, slv_rw, slv_be
  );

  modport master (
    output cpu_addr, cpu_write, as_n, uds_n, lds_n, rw, slv_read, slv_ack,
    input  cpu_read, dtack_n, berr_n, slv_addr, slv_write, slv_ds, slv_rw, slv_be
  );
endinterface

`default_nettype wire

// File: rtl/m68k_bus_responder.sv
// ----------------------------------------------------------------------------
// Module   : m68k_bus_responder
// Purpose  : Converts 68000 asynchronous-style bus cycles (AS/UDS/LDS/DTACK)
//            into a latched request/acknowledge slave transaction.
//            All CPU inputs are assumed to be synchronous to clk.
// Options  : M68K_BERR_TIMEOUT_EN - when defined, a request that is not
//            acknowledged within TIMEOUT cycles ends with a bus error.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module m68k_bus_responder #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  wire logic             clk,
  input  wire logic             reset,
  m68k_bus_responder_if.slave   bus
);

`ifdef M68K_BERR_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [c_CNT_W-1:0] r_count, w_count_next;
  logic               r_berr_n, w_berr_n_next;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;
`endif

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [15:0]       r_wdata, w_wdata_next;
  logic [15:0]       r_rdata, w_rdata_next;
  logic              r_ds, w_ds_next;
  logic              r_rw, w_rw_next;
  logic [1:0]        r_be, w_be_next;
  logic              r_dtack_n, w_dtack_n_next;
  // Set once AS has been seen released; a new cycle needs this armed so a
  // held-low AS (after a completed cycle or after reset) never re-triggers.
  logic              r_armed, w_armed_next;
  logic              w_start;

  assign w_start = !bus.as_n && (!bus.uds_n || !bus.lds_n) && r_armed;

  // Next-state and next-output decode for the bus-cycle FSM.
  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_wdata_next   = r_wdata;
    w_rdata_next   = r_rdata;
    w_ds_next      = r_ds;
    w_rw_next      = r_rw;
    w_be_next      = r_be;
    w_dtack_n_next = r_dtack_n;
    w_armed_next   = r_armed | bus.as_n;
`ifdef M68K_BERR_TIMEOUT_EN
    w_count_next   = r_count;
    w_berr_n_next  = r_berr_n;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_addr_next  = bus.cpu_addr;
          w_wdata_next = bus.cpu_write;
          w_rw_next    = bus.rw;
          w_be_next    = ~{bus.uds_n, bus.lds_n};
          w_ds_next    = 1'b1;
          w_armed_next = 1'b0;
          w_state_next = S_REQ;
`ifdef M68K_BERR_TIMEOUT_EN
          w_count_next = '0;
`endif
        end
      end
      S_REQ: begin
        if (bus.as_n) begin
          // CPU abandoned the cycle; a coincident ack is discarded.
          w_ds_next    = 1'b0;
          w_state_next = S_IDLE;
        end else if (bus.slv_ack) begin
          w_ds_next      = 1'b0;
          w_dtack_n_next = 1'b0;
          if (r_rw) begin
            w_rdata_next = bus.slv_read;
          end
          w_state_next   = S_ACK;
        end
`ifdef M68K_BERR_TIMEOUT_EN
        else if (r_count == c_CNT_W'(TIMEOUT - 1)) begin
          w_ds_next     = 1'b0;
          w_berr_n_next = 1'b0;
          w_state_next  = S_ERR;
        end else begin
          w_count_next = r_count + 1'b1;
        end
`endif
      end
      S_ACK: begin
        if (bus.as_n) begin
          w_dtack_n_next = 1'b1;
          w_state_next   = S_IDLE;
        end
      end
`ifdef M68K_BERR_TIMEOUT_EN
      S_ERR: begin
        if (bus.as_n) begin
          w_berr_n_next = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and registered-output update; reset abandons any cycle in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_ds      <= 1'b0;
      r_rw      <= 1'b1;
      r_be      <= 2'b00;
      r_dtack_n <= 1'b1;
      r_armed   <= 1'b0;
`ifdef M68K_BERR_TIMEOUT_EN
      r_count   <= '0;
      r_berr_n  <= 1'b1;
`endif
    end else begin
      r_state   <= w_state_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_rdata   <= w_rdata_next;
      r_ds      <= w_ds_next;
      r_rw      <= w_rw_next;
      r_be      <= w_be_next;
      r_dtack_n <= w_dtack_n_next;
      r_armed   <= w_armed_next;
`ifdef M68K_BERR_TIMEOUT_EN
      r_count   <= w_count_next;
      r_berr_n  <= w_berr_n_next;
`endif
    end
  end

  assign bus.slv_addr  = r_addr;
  assign bus.slv_write = r_wdata;
  assign bus.cpu_read  = r_rdata;
  assign bus.slv_ds    = r_ds;
  assign bus.slv_rw    = r_rw;
  assign bus.slv_be    = r_be;
  assign bus.dtack_n   = r_dtack_n;
`ifdef M68K_BERR_TIMEOUT_EN
  assign bus.berr_n    = r_berr_n;
`else
  assign bus.berr_n    = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_m68k_bus_responder.sv
// ----------------------------------------------------------------------------
// Module   : tb_m68k_bus_responder
// Purpose  : Self-checking bench for m68k_bus_responder. It drives random and
//            directed 68000 bus cycles. Expected slave-side values, handshake
//            timing and CPU read data are derived from each transaction's
//            parameters. Build with M68K_BERR_TIMEOUT_EN to cover the
//            bus-error timeout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_m68k_bus_responder;

  localparam int c_ADDR_W  = 32;
  localparam int c_TIMEOUT = 8;

  logic clk;
  logic reset;

  m68k_bus_responder_if #(.ADDR_W(c_ADDR_W)) bus ();

  m68k_bus_responder #(
    .ADDR_W  (c_ADDR_W),
    .TIMEOUT (c_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: data the CPU should currently see on cpu_read.
  logic [15:0] exp_rdata = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] addr, input logic [15:0] wdata,
                             input logic [1:0] be, input logic rd);
    bus.cpu_addr  = addr;
    bus.cpu_write = wdata;
    bus.rw        = rd;
    bus.uds_n     = ~be[1];
    bus.lds_n     = ~be[0];
    bus.as_n      = 1'b0;
    bus.slv_ack   = 1'b0;
  endtask

  task automatic release_as();
    bus.as_n    = 1'b1;
    bus.uds_n   = 1'b1;
    bus.lds_n   = 1'b1;
    bus.slv_ack = 1'b0;
  endtask

  // One complete bus cycle: slave acks in REQ cycle waits+1, then AS is
  // held for 'hold' more cycles before release.
  task automatic run_txn(input logic [31:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, input logic rd, input int waits,
                         input logic [15:0] rdata, input int hold);
    drive_start(addr, wdata, be, rd);
    check("idle_ds", bus.slv_ds, 1'b0);
    check("idle_dtack", bus.dtack_n, 1'b1);
    tick();
    // CPU buses change after the start; slave side must keep the latched copy.
    bus.cpu_addr  = $urandom;
    bus.cpu_write = 16'($urandom);
    for (int i = 0; i <= waits; i++) begin
      check("req_ds", bus.slv_ds, 1'b1);
      check("req_addr", bus.slv_addr, addr);
      check("req_wdata", bus.slv_write, wdata);
      check("req_rw", bus.slv_rw, rd);
      check("req_be", bus.slv_be, be);
      check("req_dtack", bus.dtack_n, 1'b1);
      check("req_berr", bus.berr_n, 1'b1);
      bus.slv_ack  = (i == waits);
      bus.slv_read = (i == waits) ? rdata : 16'($urandom);
      tick();
    end
    bus.slv_ack = 1'b0;
    if (rd) exp_rdata = rdata;
    for (int i = 0; i < hold; i++) begin
      check("ack_dtack", bus.dtack_n, 1'b0);
      check("ack_ds", bus.slv_ds, 1'b0);
      check("ack_rdata", bus.cpu_read, exp_rdata);
      bus.slv_read = 16'($urandom);
      bus.slv_ack  = 1'($urandom_range(0, 1));
      tick();
    end
    check("ack_dtack_last", bus.dtack_n, 1'b0);
    check("ack_rdata_last", bus.cpu_read, exp_rdata);
    release_as();
    tick();
    check("rel_dtack", bus.dtack_n, 1'b1);
    check("rel_ds", bus.slv_ds, 1'b0);
    check("rel_rdata", bus.cpu_read, exp_rdata);
  endtask

  initial begin
    int k;
    reset         = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_write = '0;
    bus.rw        = 1'b1;
    bus.slv_read  = '0;
    release_as();
    tick();
    tick();
    check("rst_dtack", bus.dtack_n, 1'b1);
    check("rst_berr", bus.berr_n, 1'b1);
    check("rst_ds", bus.slv_ds, 1'b0);
    check("rst_rw", bus.slv_rw, 1'b1);
    check("rst_be", bus.slv_be, 2'b00);
    check("rst_addr", bus.slv_addr, 32'h0);
    check("rst_wdata", bus.slv_write, 16'h0);
    check("rst_rdata", bus.cpu_read, 16'h0);
    reset = 1'b0;
    tick();

    // Read, both strobes, ack in first REQ cycle.
    run_txn(32'h0000_1000, 16'h0000, 2'b11, 1'b1, 0, 16'hBEEF, 3);
    // Write, lower strobe only, three wait cycles; cpu_read must not change.
    run_txn(32'h0000_2002, 16'h1234, 2'b01, 1'b0, 3, 16'h5555, 1);
    // Ack arriving on the last cycle before a timeout would fire.
    run_txn(32'h0000_3000, 16'h0000, 2'b10, 1'b1, c_TIMEOUT - 1, 16'hA5C3, 0);
`ifndef M68K_BERR_TIMEOUT_EN
    // Without the timeout, REQ waits indefinitely.
    run_txn(32'h0000_4000, 16'hCAFE, 2'b11, 1'b0, 20, 16'h0000, 0);
`endif

    // AS low with both data strobes high must not start a cycle.
    bus.as_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nods_ds", bus.slv_ds, 1'b0);
    end
    release_as();
    tick();

    // Abort: AS released in REQ together with a slave ack.
    k = $urandom_range(0, 3);
    drive_start(32'h0000_5000, 16'h0F0F, 2'b11, 1'b1);
    tick();
    for (int i = 0; i < k; i++) begin
      check("abort_req_ds", bus.slv_ds, 1'b1);
      tick();
    end
    bus.as_n    = 1'b1;
    bus.slv_ack = 1'b1;
    bus.slv_read = 16'h7777;
    tick();
    bus.slv_ack = 1'b0;
    check("abort_ds", bus.slv_ds, 1'b0);
    check("abort_dtack", bus.dtack_n, 1'b1);
    release_as();
    tick();
    check("abort_dtack2", bus.dtack_n, 1'b1);
    check("abort_rdata", bus.cpu_read, exp_rdata);

`ifdef M68K_BERR_TIMEOUT_EN
    // No ack: bus error after TIMEOUT REQ cycles, held until AS release.
    drive_start(32'h0000_6000, 16'h0000, 2'b11, 1'b1);
    tick();
    for (int i = 0; i < c_TIMEOUT; i++) begin
      check("to_req_ds", bus.slv_ds, 1'b1);
      check("to_req_berr", bus.berr_n, 1'b1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("to_berr", bus.berr_n, 1'b0);
      check("to_ds", bus.slv_ds, 1'b0);
      check("to_dtack", bus.dtack_n, 1'b1);
      tick();
    end
    release_as();
    tick();
    check("to_berr_rel", bus.berr_n, 1'b1);
`endif

    // Reset while in ACK with AS still low.
    drive_start(32'h0000_7000, 16'h0000, 2'b11, 1'b1);
    tick();
    bus.slv_ack  = 1'b1;
    bus.slv_read = 16'h1357;
    tick();
    bus.slv_ack = 1'b0;
    check("prerst_dtack", bus.dtack_n, 1'b0);
    check("prerst_rdata", bus.cpu_read, 16'h1357);
    reset = 1'b1;
    #1;
    exp_rdata = 16'h0000;
    check("arst_dtack", bus.dtack_n, 1'b1);
    check("arst_rdata", bus.cpu_read, exp_rdata);
    check("arst_addr", bus.slv_addr, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_ds", bus.slv_ds, 1'b0);
      check("postrst_dtack", bus.dtack_n, 1'b1);
    end
    release_as();
    tick();

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      logic [1:0] be;
      be = 2'($urandom_range(1, 3));
      run_txn($urandom, 16'($urandom), be, 1'($urandom_range(0, 1)),
              $urandom_range(0, c_TIMEOUT - 2), 16'($urandom),
              $urandom_range(0, 3));
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) begin
        bus.slv_ack = 1'($urandom_range(0, 1));
        tick();
        check("gap_ds", bus.slv_ds, 1'b0);
        check("gap_dtack", bus.dtack_n, 1'b1);
      end
      bus.slv_ack = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
